mod_segment_pipe: RTL

- Parametrised bit-to-waveform modulation stage; successor to the single-segment if/else BPSK selector.
- Each accepted input bit expands into SEGS output samples. Bit 0 emits the reference waveform segments; bit 1 emits the mirrored (m) waveform segments.
- Adds valid/ready handshakes on both sides, back-to-back symbols and a completed-symbol counter.
- Sits between the bit source and the DAC/sample sink of the modulation pipe.

---
 rtl/mod_segment_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mod_segment_pipe.sv
// Bit-to-waveform modulation stage: each accepted bit expands into SEGS samples
// taken from ref_wave (bit 0) or ref_wave_m (bit 1). Optional DBPSK via MOD_SEGMENT_DIFF_EN.
module mod_segment_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SEGS      = 8,
  parameter int unsigned SEG_IDX_W = $clog2(SEGS),
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  input  logic [SEGS*DATA_W-1:0] ref_wave,
  input  logic [SEGS*DATA_W-1:0] ref_wave_m,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       sym_count
);

  typedef enum logic [0:0] {IDLE, EMIT} state_e;

  localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(SEGS - 1);

  state_e                 state_q;
  logic                   rst_q;
  logic                   sel_q;
  logic [SEG_IDX_W-1:0]   seg_idx_q;
  logic                   out_valid_q;
  logic [DATA_W-1:0]      out_data_q;
  logic                   out_last_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       sym_count_q;

  logic                   accept;
  logic                   fire;
  logic                   sel_d;
  logic [SEG_IDX_W-1:0]   seg_idx_d;
  logic [DATA_W-1:0]      out_data_d;
  logic [DATA_W-1:0]      ref_seg [SEGS];
  logic [DATA_W-1:0]      m_seg   [SEGS];

  always_comb begin
    for (int unsigned k = 0; k < SEGS; k++) begin
      ref_seg[k] = ref_wave[k*DATA_W +: DATA_W];
      m_seg[k]   = ref_wave_m[k*DATA_W +: DATA_W];
    end
  end

  // rst_q keeps in_ready low while reset is held and releases it one cycle later.
  assign in_ready = !rst_q &&
                    ((state_q == IDLE) ||
                     (state_q == EMIT && seg_idx_q == LAST_IDX && out_ready));
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid_q && out_ready;

`ifdef MOD_SEGMENT_DIFF_EN
  logic prev_sym_q;

  assign sel_d = accept ? (in_bit ^ prev_sym_q) : sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sym_q <= 1'b0;
    end else if (accept) begin
      prev_sym_q <= sel_d;
    end
  end
`else
  assign sel_d = accept ? in_bit : sel_q;
`endif

  assign seg_idx_d  = accept ? '0 : seg_idx_q + SEG_IDX_W'(1);
  assign out_data_d = sel_d ? m_seg[seg_idx_d] : ref_seg[seg_idx_d];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rst_q       <= 1'b1;
      sel_q       <= 1'b0;
      seg_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      sym_count_q <= '0;
    end else begin
      rst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sel_q       <= sel_d;
            seg_idx_q   <= '0;
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          if (fire) begin
            if (seg_idx_q != LAST_IDX) begin
              seg_idx_q  <= seg_idx_d;
              out_data_q <= out_data_d;
              out_last_q <= (seg_idx_d == LAST_IDX);
            end else begin
              sym_count_q <= sym_count_q + CNT_W'(1);
              if (accept) begin
                sel_q      <= sel_d;
                seg_idx_q  <= '0;
                out_data_q <= out_data_d;
                out_last_q <= 1'b0;
              end else begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign sym_count = sym_count_q;

endmodule
